// File: rtl/io_host_driver.sv
// ----------------------------------------------------------------------------
// io_host_driver
//
// Hardware initiator for the 8-bit software/hardware handshake port of the
// AES I/O block. It plays the part normally taken by Nios II software so the
// AES datapath can be loaded and exercised without a processor (board
// self-test, bring-up).
//
// One accepted `start` pulse runs a complete transaction:
//   1. send the 128-bit message byte-serially (sig 1 = put, 2 = ack),
//   2. send the 128-bit key byte-serially     (sig 2 = put, 1 = ack),
//   3. trigger the AES run and wait for "result ready",
//   4. read the 128-bit result back byte-serially,
//   5. pulse `done`, or pulse `error` if any handshake wait times out.
//
// Parameters
//   TIMEOUT_CYCLES : cycles allowed for any single wait on to_sw_sig (>= 1)
//   GAP_CYCLES     : cycles to_hw_sig is held at 0 between phases (>= 2)
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high
//   start      in   one-cycle request, sampled only in IDLE
//   msg_in     in   [127:0] message, byte 0 = [127:120] ... byte 15 = [7:0]
//   key_in     in   [127:0] key, same byte order
//   to_hw_sig  out  [1:0]  handshake code toward the I/O block
//   to_hw_port out  [7:0]  data byte toward the I/O block
//   to_sw_sig  in   [1:0]  handshake code from the I/O block
//   to_sw_port in   [7:0]  data byte from the I/O block
//   result     out  [127:0] read-back data, byte n in the slot of input byte n
//   busy       out  high in every state except IDLE, DONE and ERR
//   done       out  one-cycle completion pulse
//   error      out  one-cycle timeout pulse
// ----------------------------------------------------------------------------
module io_host_driver #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned GAP_CYCLES     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] msg_in,
    input  logic [127:0] key_in,
    output logic [1:0]   to_hw_sig,
    output logic [7:0]   to_hw_port,
    input  logic [1:0]   to_sw_sig,
    input  logic [7:0]   to_sw_port,
    output logic [127:0] result,
    output logic         busy,
    output logic         done,
    output logic         error
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_M_PUT = 4'd1;
    localparam logic [3:0] S_M_ACK = 4'd2;
    localparam logic [3:0] S_GAP1  = 4'd3;
    localparam logic [3:0] S_K_PUT = 4'd4;
    localparam logic [3:0] S_K_ACK = 4'd5;
    localparam logic [3:0] S_GAP2  = 4'd6;
    localparam logic [3:0] S_RUN   = 4'd7;
    localparam logic [3:0] S_R_REQ = 4'd8;
    localparam logic [3:0] S_R_ACK = 4'd9;
    localparam logic [3:0] S_DONE  = 4'd10;
    localparam logic [3:0] S_ERR   = 4'd11;

    // Last count value of each counter before it acts.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [3:0]   state_q,  state_d;
    logic [3:0]   idx_q,    idx_d;
    logic [15:0]  tmo_q,    tmo_d;
    logic [15:0]  gap_q,    gap_d;
    logic [127:0] msg_q,    msg_d;
    logic [127:0] key_q,    key_d;
    logic [127:0] result_q, result_d;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------

    // Byte n of a 128-bit word, byte 0 being the most significant.
    function automatic logic [7:0] byte_sel(input logic [127:0] vec,
                                            input logic [3:0]   n);
        logic [127:0] sh;
        sh = vec << {n, 3'b000};
        return sh[127:120];
    endfunction

    logic waiting;     // state waits on a to_sw_sig condition
    logic in_gap;      // state is one of the inter-phase gaps
    logic tmo_hit;     // current wait has used its full allowance
    logic last_byte;   // current byte is byte 15

    always_comb begin
        waiting = 1'b0;
        in_gap  = 1'b0;
        case (state_q)
            S_M_PUT, S_M_ACK, S_K_PUT, S_K_ACK,
            S_RUN, S_R_REQ, S_R_ACK:  waiting = 1'b1;
            S_GAP1, S_GAP2:           in_gap  = 1'b1;
            default: ;
        endcase
    end

    assign tmo_hit   = (tmo_q == TMO_LAST);
    assign last_byte = (idx_q == 4'd15);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        msg_d    = msg_q;
        key_d    = key_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    msg_d   = msg_in;
                    key_d   = key_in;
                    idx_d   = 4'd0;
                    state_d = S_M_PUT;
                end
            end

            S_M_PUT: begin
                if (to_sw_sig == 2'd1)
                    state_d = S_M_ACK;
                else if (tmo_hit)
                    state_d = S_ERR;
            end

            S_M_ACK: begin
                if (to_sw_sig == 2'd0) begin
                    if (last_byte) begin
                        idx_d   = 4'd0;
                        state_d = S_GAP1;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_M_PUT;
                    end
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end

            S_GAP1: begin
                if (gap_q == GAP_LAST) begin
                    idx_d   = 4'd0;
                    state_d = S_K_PUT;
                end
            end

            S_K_PUT: begin
                if (to_sw_sig == 2'd1)
                    state_d = S_K_ACK;
                else if (tmo_hit)
                    state_d = S_ERR;
            end

            S_K_ACK: begin
                if (to_sw_sig == 2'd0) begin
                    if (last_byte) begin
                        idx_d   = 4'd0;
                        state_d = S_GAP2;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_K_PUT;
                    end
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end

            S_GAP2: begin
                if (gap_q == GAP_LAST)
                    state_d = S_RUN;
            end

            S_RUN: begin
                if (to_sw_sig == 2'd2) begin
                    idx_d   = 4'd0;
                    state_d = S_R_REQ;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end

            S_R_REQ: begin
                if (to_sw_sig == 2'd1) begin
                    // Only the byte slot addressed by idx is overwritten.
                    for (int unsigned i = 0; i < 16; i++) begin
                        if (idx_q == 4'(i))
                            result_d[127 - 8*i -: 8] = to_sw_port;
                    end
                    state_d = S_R_ACK;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end

            S_R_ACK: begin
                if (to_sw_sig == 2'd0) begin
                    if (last_byte) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_R_REQ;
                    end
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end

            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Both counters restart on any state change, including a PUT/ACK pair
    // returning to PUT for the next byte; they saturate rather than wrap.
    always_comb begin
        tmo_d = tmo_q;
        gap_d = gap_q;
        if (state_d != state_q) begin
            tmo_d = '0;
            gap_d = '0;
        end else begin
            if (waiting && (tmo_q != CNT_MAX))
                tmo_d = tmo_q + 16'd1;
            if (in_gap && (gap_q != CNT_MAX))
                gap_d = gap_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            tmo_q    <= '0;
            gap_q    <= '0;
            msg_q    <= '0;
            key_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            gap_q    <= gap_d;
            msg_q    <= msg_d;
            key_q    <= key_d;
            result_q <= result_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded from registered state only, so there is no path from
    // to_sw_sig to to_hw_sig within a cycle. The data byte depends on idx
    // alone, keeping it stable across both PUT and ACK of the same byte.
    // ------------------------------------------------------------------------
    always_comb begin
        to_hw_sig  = 2'd0;
        to_hw_port = 8'h00;
        case (state_q)
            S_M_PUT: begin
                to_hw_sig  = 2'd1;
                to_hw_port = byte_sel(msg_q, idx_q);
            end
            S_M_ACK: begin
                to_hw_sig  = 2'd2;
                to_hw_port = byte_sel(msg_q, idx_q);
            end
            S_K_PUT: begin
                to_hw_sig  = 2'd2;
                to_hw_port = byte_sel(key_q, idx_q);
            end
            S_K_ACK: begin
                to_hw_sig  = 2'd1;
                to_hw_port = byte_sel(key_q, idx_q);
            end
            S_RUN:   to_hw_sig = 2'd3;
            S_R_REQ: to_hw_sig = 2'd1;
            S_R_ACK: to_hw_sig = 2'd2;
            default: ;
        endcase
    end

    assign busy   = (state_q != S_IDLE) && (state_q != S_DONE) &&
                    (state_q != S_ERR);
    assign done   = (state_q == S_DONE);
    assign error  = (state_q == S_ERR);
    assign result = result_q;

endmodule

// File: doc/io_host_driver.md
# io_host_driver

Hardware initiator for the 8-bit software/hardware handshake port of the AES I/O block. It drives the side normally driven by Nios II software, so the AES datapath can be loaded and exercised without the processor (board self-test, bring-up). On one `start` pulse it:
- sends a 128-bit message and a 128-bit key byte-serially;
- triggers the AES run;
- reads the 128-bit result back byte-serially;
- reports `done`, or reports `error` on a handshake timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, 65535: maximum cycles spent waiting on any single `to_sw_sig` condition before aborting. Width 16; must be ≥ 1.
- GAP_CYCLES, 2: cycles `to_hw_sig` is held at 0 between phases. Must be ≥ 2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- msg_in  in  128  message; byte 0 = [127:120] … byte 15 = [7:0].
- key_in  in  128  key; same byte order.
- to_hw_sig  out  2  handshake code toward the I/O block.
- to_hw_port  out  8  data byte toward the I/O block.
- to_sw_sig  in  2  handshake code from the I/O block.
- to_sw_port  in  8  data byte from the I/O block.
- result  out  128  read-back data; byte n written into the same slot as input byte n.
- busy  out  1  high in every state except IDLE, DONE and ERR.
- done  out  1  one-cycle pulse on completion.
- error  out  1  one-cycle pulse on timeout.

## Operation
- `msg_in` and `key_in` are captured into internal registers on accepted `start`. Later input changes are ignored.
- Byte index `idx` is 4 bits; it resets to 0 at each phase start.
- States and outputs (`to_hw_sig` / `to_hw_port`):
  - IDLE: 0 / 0. `start` → M_PUT.
  - M_PUT: 1 / msg[idx]. Wait `to_sw_sig==1` → M_ACK.
  - M_ACK: 2 / msg[idx]. Wait `to_sw_sig==0`. Then: idx<15 → idx+1, M_PUT; idx==15 → GAP1.
  - GAP1: 0 / 0 for GAP_CYCLES cycles → K_PUT.
  - K_PUT: 2 / key[idx]. Wait `to_sw_sig==1` → K_ACK.
  - K_ACK: 1 / key[idx]. Wait `to_sw_sig==0`. Then: idx<15 → idx+1, K_PUT; idx==15 → GAP2.
  - GAP2: 0 / 0 for GAP_CYCLES cycles → RUN.
  - RUN: 3 / 0. Wait `to_sw_sig==2` (AES result ready) → R_REQ.
  - R_REQ: 1 / 0. Wait `to_sw_sig==1`; on that cycle capture `to_sw_port` into result byte idx → R_ACK.
  - R_ACK: 2 / 0. Wait `to_sw_sig==0`. Then: idx<15 → idx+1, R_REQ; idx==15 → DONE.
  - DONE: 0 / 0. `done`=1 for one cycle → IDLE.
  - ERR: 0 / 0. `error`=1 for one cycle → IDLE.
- Data byte is held stable through both PUT and ACK of the same index. This is required because the I/O block relatches the port every cycle it spends in its read state.
- Timeout: 16-bit counter, cleared on every state change, incremented each cycle in a waiting state (PUT/ACK/RUN/REQ). When count == TIMEOUT_CYCLES − 1 and the wait condition is still false, go to ERR. The counter saturates; it never wraps.
- `result` is held from the last completed transfer; it is cleared only by reset, and is not cleared on `start`. After a timeout, `result` is partially updated.

## Timing
- Reset values: all state → IDLE; `to_hw_sig`=0, `to_hw_port`=0, `result`=0, `busy`=0, `done`=0, `error`=0, idx=0, timeout counter=0.
- All outputs are registered or decoded from the registered state only. There is no combinational path from `to_sw_sig` to `to_hw_sig`.
- A wait condition true on cycle t gives the new state (and new outputs) on t+1.
- `start` while `busy` is ignored. `start` in the same cycle as `done`/`error` is ignored; the request is accepted from IDLE on the next cycle.
- `reset` asserted mid-transfer: next cycle the block is in IDLE with all reset values. The far end must also be reset.
- Minimum transfer time against a zero-latency responder: 2 cycles per byte × 48 bytes, plus 2×GAP_CYCLES, plus RUN wait, plus 1 DONE cycle.

## Test plan
- Reset → all outputs 0, `busy`=0; `to_sw_sig` held at 3 for one cycle causes no state change.
- Behavioural responder, 1-cycle reply latency, msg=0x00112233445566778899AABBCCDDEEFF, key=0x000102030405060708090A0B0C0D0E0F. Check:
  - `to_hw_port` sequence 0x00,0x11,…,0xFF, then 0x00…0x0F;
  - sig pattern 1/2 per message byte, 2/1 per key byte;
  - exactly GAP_CYCLES zeros between phases.
- RUN held 500 cycles, then responder returns bytes 0x3A,0xD7,…; `result` = 0x3AD7… and `done` pulses once.
- Responder stalls in K_ACK (byte 7) with TIMEOUT_CYCLES=16 → ERR after exactly 16 waiting cycles, `error` 1 cycle, then IDLE, `busy`=0.
- `start` pulsed during M_ACK byte 3 → ignored; byte sequence unchanged. `start` on the DONE cycle → ignored; accepted one cycle later.
- `reset` asserted in R_REQ byte 9 → IDLE next cycle, `result`=0, `to_hw_sig`=0; a new `start` then completes a full transfer.
